// File: rtl/vr_pkg.sv
// Shared types and helpers for the valid/ready blocks.
// No logic, so no latency or backpressure of its own.
package vr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b01,
        LOCK = 2'b10
    } vr_state_e;

    // Index width for n requesters; never below 1 bit.
    function automatic int vr_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vr_rr_pick.sv
// Round-robin search: first set request after ptr, wrapping modulo NREQ.
// Latency: combinational. No backpressure; it only searches.
module vr_rr_pick
    import vr_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = vr_idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);

    logic [IW-1:0] cand;

    // Walk from the far end so the candidate nearest ptr+1 is written last and wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/vr_rr_arbiter.sv
// Packet-locked round-robin arbiter onto one registered valid/ready output.
// Latency: 1 arbitration cycle per packet, then 1 cycle per beat. Backpressure: ReqRdy is low whenever the output register is full and stalled.
module vr_rr_arbiter
    import vr_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int DW   = 8,
    localparam int IW   = vr_idx_w(NREQ)
) (
    input  logic               Clk,
    input  logic               Rstn,
    input  logic               Clear,
    input  logic [NREQ*DW-1:0] ReqData,
    input  logic [NREQ-1:0]    ReqVld,
    input  logic [NREQ-1:0]    ReqLast,
    output logic [NREQ-1:0]    ReqRdy,
    output logic [DW-1:0]      DataOut,
    output logic               DataOutLast,
    output logic [IW-1:0]      DataOutId,
    output logic               DataOutVld,
    input  logic               DataOutRdy,
    output logic               Busy
);

    vr_state_e     state;
    logic [IW-1:0] gnt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic          out_free;
    logic          accept;
    logic          transmit;

    assign out_free = !DataOutVld || DataOutRdy;
    assign transmit = DataOutVld && DataOutRdy;
    assign accept   = (state == LOCK) && out_free && ReqVld[gnt];
    assign Busy     = (state == LOCK);

    always_comb begin
        ReqRdy = '0;
        if ((state == LOCK) && out_free) begin
            ReqRdy[gnt] = 1'b1;
        end
    end

    vr_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (ReqVld),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // ptr starts at NREQ-1 so requester 0 wins the first arbitration.
    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            state       <= IDLE;
            gnt         <= '0;
            ptr         <= IW'(NREQ - 1);
            DataOut     <= '0;
            DataOutLast <= 1'b0;
            DataOutId   <= '0;
            DataOutVld  <= 1'b0;
        end else if (Clear) begin
            state       <= IDLE;
            gnt         <= '0;
            ptr         <= IW'(NREQ - 1);
            DataOut     <= '0;
            DataOutLast <= 1'b0;
            DataOutId   <= '0;
            DataOutVld  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt   <= pick_idx;
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    if (accept && ReqLast[gnt]) begin
                        ptr   <= gnt;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                DataOut     <= ReqData[int'(gnt)*DW +: DW];
                DataOutLast <= ReqLast[gnt];
                DataOutId   <= gnt;
                DataOutVld  <= 1'b1;
            end else if (transmit) begin
                DataOutVld  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// Directed bench for vr_rr_arbiter (NREQ=4, DW=8): vector table plus hand-written sequences.
module tb_vr_rr_arbiter;

    logic        Clk;
    logic        Rstn;
    logic        Clear;
    logic [31:0] ReqData;
    logic [3:0]  ReqVld;
    logic [3:0]  ReqLast;
    logic [3:0]  ReqRdy;
    logic [7:0]  DataOut;
    logic        DataOutLast;
    logic [1:0]  DataOutId;
    logic        DataOutVld;
    logic        DataOutRdy;
    logic        Busy;

    int checks = 0;
    int errors = 0;

    vr_rr_arbiter #(.NREQ(4), .DW(8)) dut (
        .Clk         (Clk),
        .Rstn        (Rstn),
        .Clear       (Clear),
        .ReqData     (ReqData),
        .ReqVld      (ReqVld),
        .ReqLast     (ReqLast),
        .ReqRdy      (ReqRdy),
        .DataOut     (DataOut),
        .DataOutLast (DataOutLast),
        .DataOutId   (DataOutId),
        .DataOutVld  (DataOutVld),
        .DataOutRdy  (DataOutRdy),
        .Busy        (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        clr;
        logic [3:0]  vld;
        logic [3:0]  last;
        logic [31:0] dat;
        logic        rdy;
        logic [3:0]  e_rrdy;
        logic        e_vld;
        logic [7:0]  e_dat;
        logic [1:0]  e_id;
        logic        e_last;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_clear();
        ReqVld     = 4'h0;
        ReqLast    = 4'h0;
        DataOutRdy = 1'b1;
        Clear      = 1'b1;
        step();
        Clear      = 1'b0;
    endtask

    initial begin
        Rstn       = 1'b0;
        Clear      = 1'b0;
        ReqVld     = 4'hF;
        ReqLast    = 4'hF;
        ReqData    = 32'h33221100;
        DataOutRdy = 1'b1;

        // Round robin with every requester sending 1-beat packets.
        tbl.push_back('{1'b0, 4'hF, 4'hF, 32'h33221100, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'hF, 4'hF, 32'h33221100, 1'b1, 4'h1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'hF, 4'hF, 32'h33221100, 1'b1, 4'h0, 1'b1, 8'h00, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'hF, 4'hF, 32'h33221100, 1'b1, 4'h2, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'hF, 4'hF, 32'h33221100, 1'b1, 4'h0, 1'b1, 8'h11, 2'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'hF, 4'hF, 32'h33221100, 1'b1, 4'h4, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'hF, 4'hF, 32'h33221100, 1'b1, 4'h0, 1'b1, 8'h22, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'hF, 4'hF, 32'h33221100, 1'b1, 4'h8, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'hF, 4'hF, 32'h33221100, 1'b1, 4'h0, 1'b1, 8'h33, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'hF, 4'hF, 32'h33221100, 1'b1, 4'h1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'hF, 4'hF, 32'h33221100, 1'b1, 4'h0, 1'b1, 8'h00, 2'd0, 1'b1, 1'b0});
        // Backpressure: requester 0, 3 beats, DataOutRdy 1,0,0,1 while beats are in flight.
        tbl.push_back('{1'b1, 4'h1, 4'h0, 32'h000000D0, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'h1, 4'h0, 32'h000000D0, 1'b1, 4'h1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'h1, 4'h0, 32'h000000D1, 1'b0, 4'h0, 1'b1, 8'hD0, 2'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'h1, 4'h0, 32'h000000D1, 1'b0, 4'h0, 1'b1, 8'hD0, 2'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'h1, 4'h0, 32'h000000D1, 1'b1, 4'h1, 1'b1, 8'hD0, 2'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'h1, 4'h1, 32'h000000D2, 1'b1, 4'h1, 1'b1, 8'hD1, 2'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'h0, 4'h0, 32'h000000D2, 1'b1, 4'h0, 1'b1, 8'hD2, 2'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 4'h0, 32'h000000D2, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0});

        // Reset held with all requesters valid.
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("rst_rrdy", 32'(ReqRdy), 32'h0);
            chk("rst_vld", 32'(DataOutVld), 32'h0);
            chk("rst_dat", 32'(DataOut), 32'h0);
            chk("rst_id", 32'(DataOutId), 32'h0);
            chk("rst_last", 32'(DataOutLast), 32'h0);
            chk("rst_busy", 32'(Busy), 32'h0);
        end
        step();
        Rstn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].clr) do_clear();
            ReqVld     = tbl[i].vld;
            ReqLast    = tbl[i].last;
            ReqData    = tbl[i].dat;
            DataOutRdy = tbl[i].rdy;
            @(negedge Clk);
            chk($sformatf("tbl%0d_rrdy", i), 32'(ReqRdy), 32'(tbl[i].e_rrdy));
            chk($sformatf("tbl%0d_vld", i), 32'(DataOutVld), 32'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_busy", i), 32'(Busy), 32'(tbl[i].e_busy));
            if (tbl[i].e_vld) begin
                chk($sformatf("tbl%0d_dat", i), 32'(DataOut), 32'(tbl[i].e_dat));
                chk($sformatf("tbl%0d_id", i), 32'(DataOutId), 32'(tbl[i].e_id));
                chk($sformatf("tbl%0d_last", i), 32'(DataOutLast), 32'(tbl[i].e_last));
            end
            step();
        end

        // Single requester 2 streaming 0xA0..0xA3.
        do_clear();
        for (int c = 0; c < 7; c++) begin
            int b;
            b = (c == 0) ? 0 : ((c - 1 > 3) ? 3 : c - 1);
            ReqVld  = (c <= 4) ? 4'b0100 : 4'b0000;
            ReqLast = (b == 3) ? 4'b0100 : 4'b0000;
            ReqData = {8'h00, 8'(8'hA0 + b), 16'h0000};
            @(negedge Clk);
            chk($sformatf("str%0d_rrdy", c), 32'(ReqRdy), (c >= 1 && c <= 4) ? 32'h4 : 32'h0);
            chk($sformatf("str%0d_vld", c), 32'(DataOutVld), (c >= 2 && c <= 5) ? 32'h1 : 32'h0);
            chk($sformatf("str%0d_busy", c), 32'(Busy), (c >= 1 && c <= 4) ? 32'h1 : 32'h0);
            if (c >= 2 && c <= 5) begin
                chk($sformatf("str%0d_dat", c), 32'(DataOut), 32'(8'hA0 + c - 2));
                chk($sformatf("str%0d_id", c), 32'(DataOutId), 32'h2);
                chk($sformatf("str%0d_last", c), 32'(DataOutLast), (c == 5) ? 32'h1 : 32'h0);
            end
            step();
        end

        // Lock hold: requester 1 pauses mid-packet while requester 3 waits.
        do_clear();
        for (int c = 0; c < 12; c++) begin
            logic [3:0] erdy;
            ReqVld[3]  = (c <= 10);
            ReqLast[3] = 1'b1;
            ReqVld[1]  = (c <= 2) || (c == 8);
            ReqLast[1] = (c == 8);
            ReqVld[0]  = 1'b0;
            ReqVld[2]  = 1'b0;
            ReqData    = {8'hC0, 8'h00, ((c <= 1) ? 8'hB0 : (c == 2) ? 8'hB1 : 8'hB2), 8'h00};
            erdy = (c >= 1 && c <= 8) ? 4'b0010 : (c == 10) ? 4'b1000 : 4'b0000;
            @(negedge Clk);
            chk($sformatf("lock%0d_rrdy", c), 32'(ReqRdy), 32'(erdy));
            chk($sformatf("lock%0d_busy", c), 32'(Busy), ((c >= 1 && c <= 8) || c == 10) ? 32'h1 : 32'h0);
            if (c == 5) chk("lock5_vld", 32'(DataOutVld), 32'h0);
            if (c == 9 || c == 11) begin
                chk($sformatf("lock%0d_vld", c), 32'(DataOutVld), 32'h1);
                chk($sformatf("lock%0d_id", c), 32'(DataOutId), (c == 9) ? 32'h1 : 32'h3);
                chk($sformatf("lock%0d_dat", c), 32'(DataOut), (c == 9) ? 32'hB2 : 32'hC0);
                chk($sformatf("lock%0d_last", c), 32'(DataOutLast), 32'h1);
            end
            step();
        end

        // Clear mid-packet must drop the held beat and restore requester 0 priority.
        do_clear();
        ReqVld  = 4'b0111;
        ReqLast = 4'b0101;
        ReqData = {8'h00, 8'hF0, 8'hE0, 8'h5A};
        step();
        step();
        ReqVld = 4'b0110;
        @(negedge Clk);
        chk("clr_pick_idle", 32'(ReqRdy), 32'h0);
        step();
        @(negedge Clk);
        chk("clr_rrdy_r1", 32'(ReqRdy), 32'h2);
        step();
        ReqData = {8'h00, 8'hF0, 8'hE1, 8'h5A};
        step();
        ReqData    = {8'h00, 8'hF0, 8'hE2, 8'h5A};
        DataOutRdy = 1'b0;
        Clear      = 1'b1;
        @(negedge Clk);
        chk("clr_held_vld", 32'(DataOutVld), 32'h1);
        chk("clr_held_dat", 32'(DataOut), 32'hE1);
        chk("clr_stall_rrdy", 32'(ReqRdy), 32'h0);
        step();
        Clear      = 1'b0;
        DataOutRdy = 1'b1;
        ReqVld     = 4'b0111;
        ReqData    = {8'h00, 8'hF0, 8'hE2, 8'h5B};
        @(negedge Clk);
        chk("clr_after_vld", 32'(DataOutVld), 32'h0);
        chk("clr_after_busy", 32'(Busy), 32'h0);
        chk("clr_after_rrdy", 32'(ReqRdy), 32'h0);
        step();
        @(negedge Clk);
        chk("clr_regrant_rrdy", 32'(ReqRdy), 32'h1);
        chk("clr_regrant_busy", 32'(Busy), 32'h1);
        step();
        ReqVld = 4'b0110;
        @(negedge Clk);
        chk("clr_out_vld", 32'(DataOutVld), 32'h1);
        chk("clr_out_id", 32'(DataOutId), 32'h0);
        chk("clr_out_dat", 32'(DataOut), 32'h5B);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
